stdp_learn_array: RTL

//  Parametrised STDP learning engine: NUM_PRE pre-synaptic channels, one post-synaptic neuron.

---
 rtl/stdp_pkg.sv | 32 +++
 rtl/stdp_spike_timer.sv | 32 +++
 rtl/stdp_learn_array.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/stdp_pkg.sv
// Shared types and arithmetic helpers for the STDP learning engine.
// Every helper works on 32-bit values; callers size their results back down.
package stdp_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE      = 2'd0;
    localparam state_t S_LTP_SCAN  = 2'd1;
    localparam state_t S_LTD_APPLY = 2'd2;

    // Step shrinks linearly with spike distance; zero outside the window.
    function automatic logic [31:0] stdp_step(input logic [31:0] dt,
                                              input logic [31:0] window,
                                              input logic [31:0] shift);
        if (dt >= window) return '0;
        return (window - dt) >> shift;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, max_v}) ? max_v : sum[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage

// File: rtl/stdp_spike_timer.sv
// Time-since-last-spike counter: clears on a spike, then counts up and sticks
// at all-ones. valid_o goes high on the first spike and stays high.
module stdp_spike_timer #(
    parameter int TIME_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              spike_i,
    output logic [TIME_W-1:0] t_o,
    output logic              valid_o
);

    logic [TIME_W-1:0] t_q;
    logic              valid_q;

    // NOTE: non-blocking for all state so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q     <= '0;
            valid_q <= 1'b0;
        end else if (spike_i) begin
            t_q     <= '0;
            valid_q <= 1'b1;
        end else if (t_q != '1) begin
            t_q <= t_q + TIME_W'(1);
        end
    end

    assign t_o     = t_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/stdp_learn_array.sv
// STDP engine: one post neuron, NUM_PRE synapses. A post spike snapshots all pre
// timers and walks the channels one per cycle (LTP); pre spikes queue LTD work.
module stdp_learn_array #(
    parameter  int NUM_PRE   = 5,
    parameter  int TIME_W    = 8,
    parameter  int WEIGHT_W  = 8,
    parameter  int WINDOW    = 16,
    parameter  int LTP_SHIFT = 2,
    parameter  int LTD_SHIFT = 2,
    parameter  int W_INIT    = 2 ** (WEIGHT_W - 1),
    localparam int IDX_W     = (NUM_PRE > 1) ? $clog2(NUM_PRE) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_PRE-1:0]           pre_spike,
    input  logic                         post_spike,
    input  logic                         learn_en,
    input  logic [IDX_W-1:0]             wt_rd_idx,
    output logic [WEIGHT_W-1:0]          wt_rd_data,
    output logic [NUM_PRE*WEIGHT_W-1:0]  weights_flat,
    output logic                         upd_valid,
    output logic [IDX_W-1:0]             upd_idx,
    output logic                         upd_ltp,
    output logic [TIME_W-1:0]            upd_dt,
    output logic                         busy,
    output logic                         ovf
);

    import stdp_pkg::*;

    localparam logic [31:0] W_MAX = 32'((64'd1 << WEIGHT_W) - 64'd1);

    logic [TIME_W-1:0]   pre_t [NUM_PRE];
    logic [NUM_PRE-1:0]  pre_v;
    logic [TIME_W-1:0]   post_t;
    logic                post_v;

    for (genvar gi = 0; gi < NUM_PRE; gi++) begin : g_pre_timer
        stdp_spike_timer #(.TIME_W(TIME_W)) u_timer (
            .clk     (clk),
            .rst_n   (rst_n),
            .spike_i (pre_spike[gi]),
            .t_o     (pre_t[gi]),
            .valid_o (pre_v[gi])
        );
    end

    stdp_spike_timer #(.TIME_W(TIME_W)) u_post_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .spike_i (post_spike),
        .t_o     (post_t),
        .valid_o (post_v)
    );

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    scan_idx_q, scan_idx_d;
    logic [TIME_W-1:0]   snap_t_q [NUM_PRE];
    logic [TIME_W-1:0]   snap_t_d [NUM_PRE];
    logic [NUM_PRE-1:0]  snap_v_q, snap_v_d;
    logic [TIME_W-1:0]   ltd_dt_q [NUM_PRE];
    logic [TIME_W-1:0]   ltd_dt_d [NUM_PRE];
    logic [NUM_PRE-1:0]  pend_q, pend_d, pend_set, pend_clr;
    logic                ovf_q, ovf_d;
    logic [WEIGHT_W-1:0] w_q [NUM_PRE];

    logic                upd_valid_q;
    logic [IDX_W-1:0]    upd_idx_q;
    logic                upd_ltp_q;
    logic [TIME_W-1:0]   upd_dt_q;

    logic                post_evt;
    logic                ltd_found;
    logic [IDX_W-1:0]    ltd_idx;
    logic [31:0]         step_v, new_v;
    logic                wr_en;
    logic [IDX_W-1:0]    wr_idx;
    logic [WEIGHT_W-1:0] wr_val;
    logic                wr_ltp;
    logic [TIME_W-1:0]   wr_dt;

    assign post_evt = post_spike & learn_en;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        snap_t_d   = snap_t_q;
        snap_v_d   = snap_v_q;
        ltd_dt_d   = ltd_dt_q;
        ovf_d      = ovf_q;
        pend_set   = '0;
        pend_clr   = '0;
        step_v     = '0;
        new_v      = '0;
        wr_en      = 1'b0;
        wr_idx     = '0;
        wr_val     = '0;
        wr_ltp     = 1'b0;
        wr_dt      = '0;
        ltd_found  = 1'b0;
        ltd_idx    = '0;

        for (int i = NUM_PRE - 1; i >= 0; i--) begin
            if (pend_q[i]) begin
                ltd_found = 1'b1;
                ltd_idx   = IDX_W'(i);
            end
        end

        // A pre spike coinciding with a post spike is handled as LTP only.
        for (int i = 0; i < NUM_PRE; i++) begin
            if (pre_spike[i] && learn_en && !post_spike && post_v &&
                (32'(post_t) < 32'(WINDOW))) begin
                pend_set[i] = 1'b1;
                ltd_dt_d[i] = post_t;
            end
        end

        case (state_q)
            S_LTP_SCAN: begin
                step_v = stdp_step(32'(snap_t_q[scan_idx_q]), WINDOW, LTP_SHIFT);
                new_v  = sat_add(32'(w_q[scan_idx_q]), step_v, W_MAX);
                if (snap_v_q[scan_idx_q] && (step_v != '0) &&
                    (new_v != 32'(w_q[scan_idx_q]))) begin
                    wr_en  = 1'b1;
                    wr_idx = scan_idx_q;
                    wr_val = WEIGHT_W'(new_v);
                    wr_ltp = 1'b1;
                    wr_dt  = snap_t_q[scan_idx_q];
                end
                if (post_evt) ovf_d = 1'b1;
            end
            S_LTD_APPLY: begin
                if (!post_evt && ltd_found) begin
                    step_v = stdp_step(32'(ltd_dt_q[ltd_idx]), WINDOW, LTD_SHIFT);
                    new_v  = sat_sub(32'(w_q[ltd_idx]), step_v);
                    pend_clr[ltd_idx] = 1'b1;
                    if (new_v != 32'(w_q[ltd_idx])) begin
                        wr_en  = 1'b1;
                        wr_idx = ltd_idx;
                        wr_val = WEIGHT_W'(new_v);
                        wr_dt  = ltd_dt_q[ltd_idx];
                    end
                end
            end
            default: ;
        endcase

        pend_d = (pend_q & ~pend_clr) | pend_set;

        if (state_q == S_LTP_SCAN) begin
            if (scan_idx_q == IDX_W'(NUM_PRE - 1)) begin
                state_d = (|pend_d) ? S_LTD_APPLY : S_IDLE;
            end else begin
                scan_idx_d = scan_idx_q + IDX_W'(1);
            end
        end else if (post_evt) begin
            state_d    = S_LTP_SCAN;
            scan_idx_d = '0;
            for (int i = 0; i < NUM_PRE; i++) begin
                snap_t_d[i] = pre_spike[i] ? '0 : pre_t[i];
                snap_v_d[i] = pre_spike[i] | pre_v[i];
            end
        end else begin
            state_d = (|pend_d) ? S_LTD_APPLY : S_IDLE;
        end
    end

    // NOTE: weights live in flops rather than RAM so they can load W_INIT on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            scan_idx_q  <= '0;
            snap_v_q    <= '0;
            pend_q      <= '0;
            ovf_q       <= 1'b0;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_ltp_q   <= 1'b0;
            upd_dt_q    <= '0;
            for (int i = 0; i < NUM_PRE; i++) begin
                w_q[i]      <= WEIGHT_W'(W_INIT);
                snap_t_q[i] <= '0;
                ltd_dt_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            scan_idx_q  <= scan_idx_d;
            snap_t_q    <= snap_t_d;
            snap_v_q    <= snap_v_d;
            ltd_dt_q    <= ltd_dt_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            upd_valid_q <= wr_en;
            if (wr_en) begin
                w_q[wr_idx] <= wr_val;
                upd_idx_q   <= wr_idx;
                upd_ltp_q   <= wr_ltp;
                upd_dt_q    <= wr_dt;
            end
        end
    end

    always_comb begin
        wt_rd_data = '0;
        for (int i = 0; i < NUM_PRE; i++) begin
            if (wt_rd_idx == IDX_W'(i)) wt_rd_data = w_q[i];
        end
    end

    for (genvar gi = 0; gi < NUM_PRE; gi++) begin : g_flat
        assign weights_flat[gi*WEIGHT_W +: WEIGHT_W] = w_q[gi];
    end

    assign upd_valid = upd_valid_q;
    assign upd_idx   = upd_idx_q;
    assign upd_ltp   = upd_ltp_q;
    assign upd_dt    = upd_dt_q;
    assign busy      = (state_q != S_IDLE) | (|pend_q);
    assign ovf       = ovf_q;

endmodule
